cpu_ctrl_mem: RTL and testbench

- Next-generation Moore control FSM for the 16-bit lab CPU. Adds to the register-only controller:
  - LDR/STR memory instructions
  - HALT
  - a mem_ready wait handshake with a parametrised timeout
  - illegal-opcode detection
- Drives the datapath (register file, A/B/C/status, address register, PC, IR) and the memory command lines.
- Sits between the instruction register decoder and the datapath/memory.

---
 rtl/cpu_ctrl_mem.sv | 222 ++++++++++++++++++++++
 tb/tb_cpu_ctrl_mem.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_mem.sv
// Moore control FSM for the 16-bit lab CPU with LDR/STR, HALT, mem_ready wait timeout
// and illegal-opcode detection. Optional retired-instruction counter under CPU_CTRL_PERF_EN.
module cpu_ctrl_mem #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8,
  parameter int STATE_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic       reset_pc,
  output logic       loadpc,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       load_ir,
  output logic       load_addr,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       illegal,
  output logic       halted,
  output logic       mem_err
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF1, S_IF2, S_UPDPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXEC, S_CMPX,
    S_WB, S_ADDR, S_LDA, S_MEMRD, S_WBM, S_GETD, S_SPASS, S_MEMWR, S_HALT, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;

  logic is_movi, is_movr, is_alu, is_cmp, is_mvn, is_ldr, is_str, is_halt;
  logic in_wait, timeout;

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);
  assign is_halt = (opcode == 3'b111);

  assign in_wait = state_q inside {S_IF1, S_MEMRD, S_MEMWR};
  // A ready in the same cycle as the limit is checked before this, so it wins.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == TO_W'(MEM_TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reset_pc  = 1'b0;
    loadpc    = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = 2'b00;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    nsel      = 3'b000;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        loadpc   = 1'b1;
        state_d  = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        if (mem_ready)    state_d = S_IF2;
        else if (timeout) state_d = S_ERR;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        load_ir  = 1'b1;
        state_d  = S_UPDPC;
      end
      S_UPDPC: begin
        loadpc  = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (is_movi)                      state_d = S_WIMM;
        else if (is_movr || is_mvn)       state_d = S_GETB;
        else if (is_alu || is_ldr || is_str) state_d = S_GETA;
        else if (is_halt)                 state_d = S_HALT;
        else begin
          illegal = 1'b1;
          state_d = S_IF1;
        end
      end
      S_WIMM: begin
        nsel    = 3'b100;
        vsel    = 2'b10;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_GETA: begin
        nsel    = 3'b100;
        loada   = 1'b1;
        state_d = (is_ldr || is_str) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        nsel    = 3'b001;
        loadb   = 1'b1;
        state_d = is_cmp ? S_CMPX : S_EXEC;
      end
      S_EXEC: begin
        loadc   = 1'b1;
        asel    = is_movr || is_mvn;
        state_d = S_WB;
      end
      S_CMPX: begin
        loads   = 1'b1;
        state_d = S_IF1;
      end
      S_WB: begin
        nsel    = 3'b010;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_ADDR: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_LDA;
      end
      S_LDA: begin
        load_addr = 1'b1;
        state_d   = is_ldr ? S_MEMRD : S_GETD;
      end
      S_MEMRD: begin
        mem_cmd = 2'b01;
        if (mem_ready)    state_d = S_WBM;
        else if (timeout) state_d = S_ERR;
      end
      S_WBM: begin
        mem_cmd = 2'b01;
        nsel    = 3'b010;
        vsel    = 2'b11;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_GETD: begin
        nsel    = 3'b010;
        loadb   = 1'b1;
        state_d = S_SPASS;
      end
      S_SPASS: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_MEMWR;
      end
      S_MEMWR: begin
        mem_cmd = 2'b10;
        if (mem_ready)    state_d = S_IF1;
        else if (timeout) state_d = S_ERR;
      end
      S_HALT: halted = 1'b1;
      S_ERR: begin
        halted  = 1'b1;
        mem_err = 1'b1;
      end
      default: state_d = S_RST;
    endcase
  end

  // Any state change (including entry into a wait state) restarts the wait count.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (in_wait && !mem_ready && (wait_q != '1))
      wait_d = wait_q + 1'b1;
  end

`ifdef CPU_CTRL_PERF_EN
  logic [15:0] cnt_q;
  logic        retire;

  assign retire = (state_d == S_IF1) &&
                  (state_q inside {S_WIMM, S_CMPX, S_WB, S_WBM, S_MEMWR});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 16'd1;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_mem.sv
// Self-checking bench for cpu_ctrl_mem: per-instruction micro-op sequences with random
// mem_ready wait lengths, timeout/HALT/reset cases; checks instr_count when CPU_CTRL_PERF_EN is set.
module tb_cpu_ctrl_mem;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       mem_ready = 1'b0;
  logic       reset_pc, loadpc, addr_sel, load_ir, load_addr, write;
  logic       loada, loadb, loadc, loads, asel, bsel, illegal, halted, mem_err;
  logic [1:0] mem_cmd, vsel;
  logic [2:0] nsel;
`ifdef CPU_CTRL_PERF_EN
  logic [15:0] instr_count;
`endif

  cpu_ctrl_mem #(.MEM_TIMEOUT(TO), .TO_W(8), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .reset_pc(reset_pc), .loadpc(loadpc), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
    .load_ir(load_ir), .load_addr(load_addr), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .illegal(illegal), .halted(halted), .mem_err(mem_err)
`ifdef CPU_CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {reset_pc, loadpc, addr_sel, mem_cmd, load_ir, load_addr, nsel, vsel,
                write, loada, loadb, loadc, loads, asel, bsel, illegal, halted, mem_err};

  // Expected output bundles, laid out as in obs.
  localparam logic [21:0] B_RPC = 22'd1 << 21, B_LPC = 22'd1 << 20, B_ASL = 22'd1 << 19;
  localparam logic [21:0] MC_RD = 22'd1 << 17, MC_WR = 22'd2 << 17;
  localparam logic [21:0] B_LIR = 22'd1 << 16, B_LAD = 22'd1 << 15;
  localparam logic [21:0] N_RM = 22'd1 << 12, N_RD = 22'd2 << 12, N_RN = 22'd4 << 12;
  localparam logic [21:0] V_PC = 22'd1 << 10, V_IMM = 22'd2 << 10, V_MD = 22'd3 << 10;
  localparam logic [21:0] B_WR = 22'd1 << 9, B_LA = 22'd1 << 8, B_LB = 22'd1 << 7;
  localparam logic [21:0] B_LC = 22'd1 << 6, B_LS = 22'd1 << 5, B_AS = 22'd1 << 4;
  localparam logic [21:0] B_BS = 22'd1 << 3, B_ILL = 22'd1 << 2, B_HLT = 22'd1 << 1;
  localparam logic [21:0] B_ERR = 22'd1;

  localparam logic [21:0] O_RST   = B_RPC | B_LPC;
  localparam logic [21:0] O_IF1   = B_ASL | MC_RD;
  localparam logic [21:0] O_IF2   = B_ASL | MC_RD | B_LIR;
  localparam logic [21:0] O_UPD   = B_LPC;
  localparam logic [21:0] O_WIMM  = N_RN | V_IMM | B_WR;
  localparam logic [21:0] O_GETA  = N_RN | B_LA;
  localparam logic [21:0] O_GETB  = N_RM | B_LB;
  localparam logic [21:0] O_CMPX  = B_LS;
  localparam logic [21:0] O_WB    = N_RD | B_WR;
  localparam logic [21:0] O_ADDR  = B_BS | B_LC;
  localparam logic [21:0] O_LDA   = B_LAD;
  localparam logic [21:0] O_MEMRD = MC_RD;
  localparam logic [21:0] O_WBM   = MC_RD | N_RD | V_MD | B_WR;
  localparam logic [21:0] O_GETD  = N_RD | B_LB;
  localparam logic [21:0] O_SPASS = B_AS | B_LC;
  localparam logic [21:0] O_MEMWR = MC_WR;
  localparam logic [21:0] O_HALT  = B_HLT;
  localparam logic [21:0] O_ERR   = B_HLT | B_ERR;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [21:0] eq[$];
  bit          rq[$];
  bit          dead;

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef CPU_CTRL_PERF_EN
    chk(tag, 22'(instr_count), 22'(exp_cnt[15:0]));
`endif
  endtask

  // One clock cycle: drive ready, compare mid-cycle, advance past the edge.
  task automatic cyc(input logic [21:0] e, input bit r, input string tag);
    mem_ready = r;
    @(negedge clk);
    chk(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [21:0] v, input bit r);
    eq.push_back(v);
    rq.push_back(r);
  endfunction

  function automatic void add_wait(input logic [21:0] v, input int w);
    if (w > TO) begin
      repeat (TO + 1) push(v, 1'b0);
      repeat (3) push(O_ERR, 1'($urandom));
      dead = 1'b1;
    end else begin
      repeat (w) push(v, 1'b0);
      push(v, 1'b1);
    end
  endfunction

  task automatic run_instr(input string name, input logic [2:0] oc, input logic [1:0] o,
                           input int w1, input int wm, input int limit);
    bit movi, movr, alu, cmp, mvn, ldr, str, hlt, legal;
    int n, total;
    logic [21:0] e;
    bit r;
    movi = (oc == 3'b110) && (o == 2'b10);
    movr = (oc == 3'b110) && (o == 2'b00);
    alu  = (oc == 3'b101);
    cmp  = alu && (o == 2'b01);
    mvn  = alu && (o == 2'b11);
    ldr  = (oc == 3'b011) && (o == 2'b00);
    str  = (oc == 3'b100) && (o == 2'b00);
    hlt  = (oc == 3'b111);
    legal = movi | movr | alu | ldr | str | hlt;
    eq.delete();
    rq.delete();
    dead = 1'b0;
    opcode = oc;
    op = o;
    add_wait(O_IF1, w1);
    if (!dead) begin
      push(O_IF2, 1'($urandom));
      push(O_UPD, 1'($urandom));
      push(legal ? 22'd0 : B_ILL, 1'($urandom));
      if (movi) push(O_WIMM, 1'($urandom));
      else if (hlt) repeat (5) push(O_HALT, 1'($urandom));
      else if (movr || mvn) begin
        push(O_GETB, 1'($urandom)); push(B_LC | B_AS, 1'($urandom)); push(O_WB, 1'($urandom));
      end else if (cmp) begin
        push(O_GETA, 1'($urandom)); push(O_GETB, 1'($urandom)); push(O_CMPX, 1'($urandom));
      end else if (alu) begin
        push(O_GETA, 1'($urandom)); push(O_GETB, 1'($urandom));
        push(B_LC, 1'($urandom)); push(O_WB, 1'($urandom));
      end else if (ldr || str) begin
        push(O_GETA, 1'($urandom)); push(O_ADDR, 1'($urandom)); push(O_LDA, 1'($urandom));
        if (ldr) begin
          add_wait(O_MEMRD, wm);
          if (!dead) push(O_WBM, 1'($urandom));
        end else begin
          push(O_GETD, 1'($urandom)); push(O_SPASS, 1'($urandom));
          add_wait(O_MEMWR, wm);
        end
      end
    end
    total = eq.size();
    n = 0;
    while (eq.size() > 0 && n < limit) begin
      e = eq.pop_front();
      r = rq.pop_front();
      cyc(e, r, $sformatf("%s#%0d", name, n));
      n++;
    end
    if (!dead && legal && !hlt && n == total) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk_cnt({name, "_count"});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_async"}, obs, O_RST);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    chk_cnt({tag, "_count"});
    cyc(O_RST, 1'b1, {tag, "_hold"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] roc;
    logic [1:0] rop;
    #2;
    do_reset("por");
    run_instr("movi", 3'b110, 2'b10, 0, 0, 1000);
    run_instr("cmp", 3'b101, 2'b01, 0, 0, 1000);
    run_instr("ldr_w3", 3'b011, 2'b00, 0, 3, 1000);
    run_instr("str", 3'b100, 2'b00, 1, 2, 1000);
    run_instr("add", 3'b101, 2'b00, 0, 0, 1000);
    run_instr("and", 3'b101, 2'b10, 2, 0, 1000);
    run_instr("mvn", 3'b101, 2'b11, 0, 0, 1000);
    run_instr("movr", 3'b110, 2'b00, 0, 0, 1000);
    run_instr("ill000", 3'b000, 2'b00, 0, 0, 1000);
    run_instr("movi2", 3'b110, 2'b10, 0, 0, 1000);
    run_instr("ill110_01", 3'b110, 2'b01, 0, 0, 1000);
    run_instr("ill011_01", 3'b011, 2'b01, 0, 0, 1000);
    run_instr("if1_edge", 3'b110, 2'b10, TO, 0, 1000);
    run_instr("memrd_edge", 3'b011, 2'b00, 0, TO, 1000);
    run_instr("memwr_edge", 3'b100, 2'b00, 0, TO, 1000);
    for (int i = 0; i < 40; i++) begin
      roc = 3'($urandom_range(0, 6));
      rop = 2'($urandom);
      run_instr($sformatf("rnd%0d", i), roc, rop, $urandom_range(0, 3),
                $urandom_range(0, 3), 1000);
    end
    run_instr("midop_ldr", 3'b011, 2'b00, 0, 10, 10);
    do_reset("midop_rst");
    run_instr("post_rst", 3'b101, 2'b00, 0, 0, 1000);
    run_instr("to_if1", 3'b110, 2'b10, TO + 1, 0, 1000);
    do_reset("to_if1_rst");
    run_instr("to_memrd", 3'b011, 2'b00, 0, TO + 1, 1000);
    do_reset("to_memrd_rst");
    run_instr("to_memwr", 3'b100, 2'b00, 0, TO + 1, 1000);
    do_reset("to_memwr_rst");
    run_instr("halt", 3'b111, 2'b10, 0, 0, 1000);
    do_reset("halt_rst");
    run_instr("final_movi", 3'b110, 2'b10, 0, 0, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
